data_mem_responder: RTL and testbench

- Memory-side responder for the datapath's data-memory port: the far end of the load/store traffic the processor initiates.
- Accepts one request at a time over a valid/ready handshake, waits a configurable latency, then performs it.
- Supports word stores, byte stores (lane chosen by address[1:0]) and reads.
- Returns the addressed aligned word plus an error flag over a valid/ready response handshake.
- Replaces the zero-latency data memory for multicycle and cache-fill work.

---
 rtl/data_mem_responder_pkg.sv | 32 +++
 rtl/data_mem_responder_if.sv | 31 +++
 rtl/data_mem_responder_byte_lane_merge.sv | 15 +
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Imported by the interface, the top and the byte-lane merge.
package data_mem_resp_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int LAT_CNT_W = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        word_we;
      logic        byte_we;
      logic        read;
   } req_t;

   // 33-bit compare so a window ending at 4 GiB never wraps
   function automatic logic in_range(
      input logic [31:0] addr,
      input logic [31:0] base,
      input int unsigned aw
   );
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + (33'd4 << aw);
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between initiator and responder.
// master = initiator side, slave = memory side.
interface data_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_word_we;
   logic        req_byte_we;
   logic        req_read;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_error;

   modport master (
      output req_valid, req_addr, req_wdata,
      output req_word_we, req_byte_we, req_read,
      output resp_ready,
      input  req_ready, resp_valid, resp_data, resp_error
   );

   modport slave (
      input  req_valid, req_addr, req_wdata,
      input  req_word_we, req_byte_we, req_read,
      input  resp_ready,
      output req_ready, resp_valid, resp_data, resp_error
   );

endinterface

// File: rtl/data_mem_responder_byte_lane_merge.sv
// Replaces one byte lane of a 32-bit word, keeping the other lanes.
// Purely combinational; shared with the cache fill path.
module byte_lane_merge (
   input  logic [31:0] old_word,
   input  logic [7:0]  byte_val,
   input  logic [1:0]  lane,
   output logic [31:0] new_word
);

   always_comb begin
      new_word = old_word;
      new_word[8*lane +: 8] = byte_val;
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, fixed latency,
// word/byte stores and aligned-word reads with error flagging.
module data_mem_responder
   import data_mem_resp_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter int          LATENCY    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic clock,
   input  logic reset,
   data_mem_responder_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [31:0] mem [DEPTH];

   state_t                state;
   state_t                nxt;
   logic [LAT_CNT_W-1:0]  cnt;
   logic [LAT_CNT_W-1:0]  cnt_nxt;
   logic                  accept;
   logic                  enter_resp;

   req_t                  held;
   req_t                  cur;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           old_word;
   logic [31:0]           merged;
   logic [31:0]           new_word;
   logic                  err;
   logic [31:0]           data_q;
   logic                  err_q;

   // With LATENCY==1 RESP is entered straight from IDLE, so the
   // request has to come from the bus rather than the held copy.
   always_comb begin
      cur = held;
      if (state == IDLE) begin
         cur.addr    = bus.req_addr;
         cur.wdata   = bus.req_wdata;
         cur.word_we = bus.req_word_we;
         cur.byte_we = bus.req_byte_we;
         cur.read    = bus.req_read;
      end
   end

   assign idx      = ADDR_WIDTH'((cur.addr - BASE_ADDR) >> 2);
   assign old_word = mem[idx];

   byte_lane_merge u_merge (
      .old_word (old_word),
      .byte_val (cur.wdata[7:0]),
      .lane     (cur.addr[1:0]),
      .new_word (merged)
   );

   always_comb begin
      new_word = old_word;
      if (cur.word_we)
         new_word = cur.wdata;
      else if (cur.byte_we)
         new_word = merged;
   end

   assign err = !in_range(cur.addr, BASE_ADDR, ADDR_WIDTH)
             || (cur.word_we && (cur.addr[1:0] != 2'b00))
             || (cur.word_we && cur.byte_we);

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      accept  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept  = 1'b1;
               cnt_nxt = LAT_CNT_W'(LATENCY - 1);
               nxt     = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == LAT_CNT_W'(1))
               nxt = RESP;
         end
         RESP: begin
            if (bus.resp_ready)
               nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign enter_resp = (nxt == RESP) && (state != RESP);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         held   <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (accept)
            held <= cur;
         if (enter_resp) begin
            data_q <= err ? 32'h0 : new_word;
            err_q  <= err;
            if (!err && (cur.word_we || cur.byte_we))
               mem[idx] <= new_word;
         end
      end
   end

   assign bus.req_ready  = reset || (state == IDLE);
   assign bus.resp_valid = !reset && (state == RESP);
   assign bus.resp_data  = reset ? 32'h0 : data_q;
   assign bus.resp_error = !reset && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at default parameters.
// Inputs driven and outputs sampled on the falling edge.
module tb_data_mem_responder;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .ADDR_WIDTH (10),
      .LATENCY    (2),
      .BASE_ADDR  (32'h1000_0000)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus();
      bus.req_valid   = 1'b0;
      bus.req_addr    = 32'h0;
      bus.req_wdata   = 32'h0;
      bus.req_word_we = 1'b0;
      bus.req_byte_we = 1'b0;
      bus.req_read    = 1'b0;
   endtask

   // Drive at a falling edge, accepted at the next rising edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic b, input logic r);
      @(negedge clock);
      bus.req_valid   = 1'b1;
      bus.req_addr    = a;
      bus.req_wdata   = d;
      bus.req_word_we = w;
      bus.req_byte_we = b;
      bus.req_read    = r;
      @(negedge clock);
      idle_bus();
   endtask

   // Counts falling edges after acceptance until resp_valid.
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic txn(input string tag, input logic [31:0] a,
                      input logic [31:0] d, input logic w,
                      input logic b, input logic r,
                      input logic [31:0] exp_d, input logic exp_e);
      int lat;
      issue(a, d, w, b, r);
      wait_resp(lat);
      check({tag, "_lat"}, 32'(lat), 32'd2);
      check({tag, "_data"}, bus.resp_data, exp_d);
      check({tag, "_err"}, 32'(bus.resp_error), 32'(exp_e));
      bus.resp_ready = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
      check({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      int lat;
      idle_bus();
      bus.resp_ready = 1'b0;

      // reset state
      repeat (3) @(negedge clock);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_data", bus.resp_data, 32'h0);
      check("rst_resp_error", 32'(bus.resp_error), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);

      txn("rd0", 32'h1000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

      // word store then read back
      txn("sw4", 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0,
          32'hDEAD_BEEF, 1'b0);
      txn("rd4", 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b1,
          32'hDEAD_BEEF, 1'b0);

      // byte store into lane 1
      txn("sb5", 32'h1000_0005, 32'h0000_00AA, 1'b0, 1'b1, 1'b0,
          32'hDEAD_AAEF, 1'b0);
      txn("rd4b", 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b1,
          32'hDEAD_AAEF, 1'b0);
      txn("rd7", 32'h1000_0007, 32'h0, 1'b0, 1'b0, 1'b1,
          32'hDEAD_AAEF, 1'b0);
      txn("sb7", 32'h1000_0007, 32'h0000_0011, 1'b0, 1'b1, 1'b1,
          32'h11AD_AAEF, 1'b0);

      // error cases leave memory alone
      txn("sw_unal", 32'h1000_0006, 32'h5555_5555, 1'b1, 1'b0, 1'b0,
          32'h0, 1'b1);
      txn("sw_low", 32'h0FFF_FFFC, 32'h5555_5555, 1'b1, 1'b0, 1'b0,
          32'h0, 1'b1);
      txn("sw_high", 32'h1000_1000, 32'h5555_5555, 1'b1, 1'b0, 1'b0,
          32'h0, 1'b1);
      txn("sw_both", 32'h1000_0004, 32'h5555_5555, 1'b1, 1'b1, 1'b0,
          32'h0, 1'b1);
      txn("rd4c", 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b1,
          32'h11AD_AAEF, 1'b0);
      txn("sw_last", 32'h1000_0FFC, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0,
          32'hCAFE_F00D, 1'b0);
      txn("rd_high", 32'h1000_1000, 32'h0, 1'b0, 1'b0, 1'b1,
          32'h0, 1'b1);
      txn("noop", 32'h1000_0FFC, 32'h0, 1'b0, 1'b0, 1'b0,
          32'hCAFE_F00D, 1'b0);

      // back-pressure: response held, new requests ignored
      issue(32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b1);
      wait_resp(lat);
      check("bp_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 3; i++) begin
         bus.req_valid   = i[0] ? 1'b0 : 1'b1;
         bus.req_addr    = 32'h1000_0000 + 32'(4 * i);
         bus.req_wdata   = 32'hFFFF_FFFF;
         bus.req_word_we = 1'b1;
         @(negedge clock);
         check("bp_valid", 32'(bus.resp_valid), 32'd1);
         check("bp_data", bus.resp_data, 32'h11AD_AAEF);
         check("bp_err", 32'(bus.resp_error), 32'd0);
         check("bp_ready", 32'(bus.req_ready), 32'd0);
      end
      idle_bus();
      bus.resp_ready = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
      check("bp_done_valid", 32'(bus.resp_valid), 32'd0);
      txn("bp_rd0", 32'h1000_0000, 32'h0, 1'b0, 1'b0, 1'b1,
          32'h0, 1'b0);
      txn("bp_rd8", 32'h1000_0008, 32'h0, 1'b0, 1'b0, 1'b1,
          32'h0, 1'b0);

      // reset during WAIT drops the store
      issue(32'h1000_0008, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      check("mid_wait_valid", 32'(bus.resp_valid), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_valid", 32'(bus.resp_valid), 32'd0);
      txn("rst_rd8", 32'h1000_0008, 32'h0, 1'b0, 1'b0, 1'b1,
          32'h0, 1'b0);
      txn("rst_rd4", 32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b1,
          32'h0, 1'b0);

      // reset beats a simultaneous response handshake
      issue(32'h1000_0004, 32'h0, 1'b0, 1'b0, 1'b1);
      wait_resp(lat);
      check("rw_lat", 32'(lat), 32'd2);
      bus.resp_ready = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      bus.resp_ready = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      check("rw_valid", 32'(bus.resp_valid), 32'd0);
      check("rw_ready", 32'(bus.req_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
